// File: rtl/bus_demux1x2.sv
// Single-master to two-slave data-bus demultiplexer for the memory stage.
// Routes one load/store by address to data memory (s0) or MMIO (s1), with a per-transaction timeout.
module bus_demux1x2 #(
   parameter int unsigned   AW      = 32,
   parameter int unsigned   DW      = 32,
   parameter logic [AW-1:0] IO_BASE = AW'(32'hFFFF_0000),
   parameter int unsigned   TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // master side
   input  logic          m_req,
   input  logic          m_we,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_wdata,
   output logic [DW-1:0] m_rdata,
   output logic          m_ack,
   output logic          m_err,
   // slave 0: data memory
   output logic          s0_req,
   output logic          s0_we,
   output logic [AW-1:0] s0_addr,
   output logic [DW-1:0] s0_wdata,
   input  logic [DW-1:0] s0_rdata,
   input  logic          s0_ack,
   // slave 1: memory-mapped I/O
   output logic          s1_req,
   output logic          s1_we,
   output logic [AW-1:0] s1_addr,
   output logic [DW-1:0] s1_wdata,
   input  logic [DW-1:0] s1_rdata,
   input  logic          s1_ack
);

   localparam int unsigned   CW      = 8;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   state_e        state_q, state_d;
   req_t          req_q, req_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s0_req_q, s0_req_d;
   logic          s1_req_q, s1_req_d;
   logic          m_ack_q, m_ack_d;
   logic          m_err_q, m_err_d;
   logic [DW-1:0] m_rdata_q, m_rdata_d;

   // Ack/data of the slave currently being served; the other slave is never looked at.
   logic          sel_ack_c;
   logic [DW-1:0] sel_rdata_c;

   assign sel_ack_c   = (state_q == BUSY1) ? s1_ack   : s0_ack;
   assign sel_rdata_c = (state_q == BUSY1) ? s1_rdata : s0_rdata;

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      cnt_d     = cnt_q;
      s0_req_d  = 1'b0;
      s1_req_d  = 1'b0;
      m_ack_d   = 1'b0;
      m_err_d   = 1'b0;
      m_rdata_d = m_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (m_req) begin
               req_d.we    = m_we;
               req_d.addr  = m_addr;
               req_d.wdata = m_wdata;
               cnt_d       = '0;
               if (m_addr >= IO_BASE) begin
                  state_d  = BUSY1;
                  s1_req_d = 1'b1;
               end else begin
                  state_d  = BUSY0;
                  s0_req_d = 1'b1;
               end
            end
         end

         BUSY0, BUSY1: begin
            if (sel_ack_c) begin
               // Ack beats a timeout landing in the same cycle.
               m_rdata_d = sel_rdata_c;
               m_ack_d   = 1'b1;
               state_d   = RESP;
            end else if (cnt_q == TO_LAST) begin
               m_rdata_d = '0;
               m_err_d   = 1'b1;
               m_ack_d   = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
               s0_req_d = (state_q == BUSY0);
               s1_req_d = (state_q == BUSY1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         req_q     <= '0;
         cnt_q     <= '0;
         s0_req_q  <= 1'b0;
         s1_req_q  <= 1'b0;
         m_ack_q   <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         cnt_q     <= cnt_d;
         s0_req_q  <= s0_req_d;
         s1_req_q  <= s1_req_d;
         m_ack_q   <= m_ack_d;
         m_err_q   <= m_err_d;
         m_rdata_q <= m_rdata_d;
      end
   end

   // Both slaves see the latched request; only req is steered.
   assign s0_req   = s0_req_q;
   assign s1_req   = s1_req_q;
   assign s0_we    = req_q.we;
   assign s1_we    = req_q.we;
   assign s0_addr  = req_q.addr;
   assign s1_addr  = req_q.addr;
   assign s0_wdata = req_q.wdata;
   assign s1_wdata = req_q.wdata;
   assign m_ack    = m_ack_q;
   assign m_err    = m_err_q;
   assign m_rdata  = m_rdata_q;

endmodule

// File: tb/tb_bus_demux1x2.sv
// Self-checking bench for bus_demux1x2: directed and randomized transactions
// checked against a per-transaction outcome model (route, req length, error, data).
module tb_bus_demux1x2;

   localparam int unsigned AW      = 32;
   localparam int unsigned DW      = 32;
   localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
   localparam int          TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m_req, m_we;
   logic [31:0]   m_addr, m_wdata;
   logic [31:0]   m_rdata;
   logic          m_ack, m_err;
   logic          s0_req, s0_we, s0_ack;
   logic [31:0]   s0_addr, s0_wdata, s0_rdata;
   logic          s1_req, s1_we, s1_ack;
   logic [31:0]   s1_addr, s1_wdata, s1_rdata;

   int checks = 0;
   int errors = 0;

   bus_demux1x2 #(
      .AW(AW), .DW(DW), .IO_BASE(IO_BASE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
      .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
      .s0_rdata(s0_rdata), .s0_ack(s0_ack),
      .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
      .s1_rdata(s1_rdata), .s1_ack(s1_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".m_rdata"},  m_rdata,  32'h0);
      check({tag, ".m_ack"},    32'(m_ack), 32'h0);
      check({tag, ".m_err"},    32'(m_err), 32'h0);
      check({tag, ".s0_req"},   32'(s0_req), 32'h0);
      check({tag, ".s1_req"},   32'(s1_req), 32'h0);
      check({tag, ".s0_we"},    32'(s0_we), 32'h0);
      check({tag, ".s1_we"},    32'(s1_we), 32'h0);
      check({tag, ".s0_addr"},  s0_addr,  32'h0);
      check({tag, ".s1_addr"},  s1_addr,  32'h0);
      check({tag, ".s0_wdata"}, s0_wdata, 32'h0);
      check({tag, ".s1_wdata"}, s1_wdata, 32'h0);
   endtask

   // One full transaction. ack_at = req cycle (1-based) on which the selected slave
   // acks; 0 or > TIMEOUT means it never does. Called just after an edge, DUT in IDLE.
   task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input int ack_at,
                          input logic [31:0] rd, input logic spur);
      logic        exp_s1, exp_err, other_seen, got_ack, hit;
      int          exp_hold, req_cnt, edges;
      logic [31:0] exp_rd;

      exp_s1   = (addr >= IO_BASE);
      exp_err  = (ack_at < 1) || (ack_at > TIMEOUT);
      exp_hold = exp_err ? TIMEOUT : ack_at;
      exp_rd   = exp_err ? 32'h0 : rd;

      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
      @(posedge clk); #1;
      edges = 1;
      // Master bus may wander once accepted; the latched copy must hold.
      m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom);

      check({tag, ".s1_req"},   32'(s1_req), 32'(exp_s1));
      check({tag, ".s0_req"},   32'(s0_req), 32'(!exp_s1));
      check({tag, ".s0_addr"},  s0_addr, addr);
      check({tag, ".s1_addr"},  s1_addr, addr);
      check({tag, ".we"},       32'(exp_s1 ? s1_we : s0_we), 32'(we));
      check({tag, ".wdata"},    exp_s1 ? s1_wdata : s0_wdata, wdata);

      req_cnt = 0; other_seen = 1'b0; got_ack = 1'b0;
      for (int c = 1; c <= TIMEOUT + 4 && !got_ack; c++) begin
         if (exp_s1 ? s1_req : s0_req) req_cnt++;
         if (exp_s1 ? s0_req : s1_req) other_seen = 1'b1;
         hit = (c == ack_at);
         if (exp_s1) begin
            s1_ack = hit;  s1_rdata = hit ? rd : $urandom;
            s0_ack = spur; s0_rdata = $urandom;
         end else begin
            s0_ack = hit;  s0_rdata = hit ? rd : $urandom;
            s1_ack = spur; s1_rdata = $urandom;
         end
         @(posedge clk); #1;
         edges++;
         got_ack = m_ack;
      end
      s0_ack = 1'b0; s1_ack = 1'b0;

      check({tag, ".m_ack"},      32'(got_ack), 32'h1);
      check({tag, ".req_cycles"}, 32'(req_cnt), 32'(exp_hold));
      check({tag, ".latency"},    32'(edges), 32'(exp_hold + 1));
      check({tag, ".other_req"},  32'(other_seen), 32'h0);
      check({tag, ".m_err"},      32'(m_err), 32'(exp_err));
      check({tag, ".m_rdata"},    m_rdata, exp_rd);
      check({tag, ".req_off"},    32'(s0_req | s1_req), 32'h0);
      check({tag, ".addr_held"},  s0_addr, addr);

      m_req = 1'b0;
      @(posedge clk); #1;
      check({tag, ".ack_pulse"}, 32'(m_ack), 32'h0);
      check({tag, ".err_pulse"}, 32'(m_err), 32'h0);
   endtask

   initial begin
      logic        ack_seen;
      logic [31:0] ra;

      // Reset with unknown inputs: all outputs must be zero.
      rst_n = 1'b0;
      m_req = 'x; m_we = 'x; m_addr = 'x; m_wdata = 'x;
      s0_ack = 'x; s1_ack = 'x; s0_rdata = 'x; s1_rdata = 'x;
      #3;
      check_all_zero("reset_x");
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      s0_ack = 1'b0; s1_ack = 1'b0; s0_rdata = '0; s1_rdata = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      check_all_zero("reset_0");
      @(posedge clk); #1;

      // Reset mid-transaction: s0_req drops without an edge, no m_ack afterwards.
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_2000; m_wdata = '0;
      @(posedge clk); #1;
      check("mid_rst.s0_req_before", 32'(s0_req), 32'h1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst.s0_req_async", 32'(s0_req), 32'h0);
      m_req = 1'b0;
      check_all_zero("mid_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      ack_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (m_ack) ack_seen = 1'b1;
      end
      check("mid_rst.no_ack", 32'(ack_seen), 32'h0);

      // Directed scenarios.
      run_txn("rd_s0",      32'h0000_1000, 1'b0, 32'h0,         3, 32'hDEAD_BEEF, 1'b0);
      run_txn("wr_s1_zw",   32'hFFFF_0004, 1'b1, 32'h0000_00A5, 1, 32'h1234_5678, 1'b0);
      run_txn("bnd_below",  32'hFFFE_FFFF, 1'b0, 32'h0,         2, 32'h0BAD_F00D, 1'b0);
      run_txn("bnd_base",   32'hFFFF_0000, 1'b0, 32'h0,         2, 32'hCAFE_0001, 1'b0);
      run_txn("spur_s1",    32'h0000_0040, 1'b0, 32'h0,         4, 32'h5555_AAAA, 1'b1);
      run_txn("timeout",    32'h0000_0080, 1'b0, 32'h0,         0, 32'h7777_7777, 1'b0);
      run_txn("ack_at_lim", 32'h0000_0084, 1'b0, 32'h0,   TIMEOUT, 32'h1357_9BDF, 1'b0);
      run_txn("to_s1_spur", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 0, 32'h2222_2222, 1'b1);

      // Randomized transactions, biased toward the routing boundary.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       ra = IO_BASE + 32'($urandom_range(0, 255));
            1:       ra = IO_BASE - 32'h1 - 32'($urandom_range(0, 255));
            default: ra = $urandom;
         endcase
         run_txn($sformatf("rnd%0d", n), ra, 1'($urandom), $urandom,
                 $urandom_range(0, TIMEOUT + 2), $urandom, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bus_demux1x2.md
# bus_demux1x2

Single-master to two-slave data-bus demultiplexer for the CPU memory stage. Accepts one load/store request from the core and routes it by address to data memory (slave 0) or the memory-mapped I/O region (slave 1). It then returns read data and a one-cycle acknowledge to the core. A per-transaction timeout returns an error if the selected slave never acknowledges.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- IO_BASE, 32'hFFFF_0000, addresses >= IO_BASE route to slave 1; all others route to slave 0
- TIMEOUT, 16, cycles of unacknowledged slave request before error; legal range 2..255

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- m_req  in  1  core request; held high until m_ack
- m_we  in  1  1 = write, 0 = read
- m_addr  in  AW  request address
- m_wdata  in  DW  write data
- m_rdata  out  DW  read data, valid while m_ack = 1
- m_ack  out  1  one-cycle completion pulse
- m_err  out  1  high with m_ack when the transaction timed out
- s0_req, s1_req  out  1  slave request, held until that slave's ack
- s0_we, s1_we  out  1  latched m_we
- s0_addr, s1_addr  out  AW  latched m_addr
- s0_wdata, s1_wdata  out  DW  latched m_wdata
- s0_rdata, s1_rdata  in  DW  slave read data, valid with that slave's ack
- s0_ack, s1_ack  in  1  slave completion; sampled only while that slave's req is high

## Operation
- States: IDLE, BUSY0, BUSY1, RESP.
- IDLE: when m_req = 1, latch m_we/m_addr/m_wdata and compute the route (m_addr >= IO_BASE, unsigned compare).
  - Go to BUSY1 if routed to slave 1, otherwise BUSY0.
  - Clear the timeout counter.
- BUSYn: sn_req = 1; the other slave's req = 0. Address, we and wdata are driven to both slaves from the latched registers; only req is gated.
  - If sn_ack = 1: capture sn_rdata into m_rdata (writes capture too; the value is don't-care), clear err, and go to RESP.
  - Else, if counter == TIMEOUT-1: set err, set m_rdata = 0, and go to RESP.
  - Else: increment the counter (8-bit, saturating).
  - Ack from the non-selected slave is ignored in all states.
- RESP: m_ack = 1 and m_err = err for exactly one cycle; s0_req = s1_req = 0; return to IDLE.
  - m_req must drop in the cycle after m_ack. It is sampled again only in IDLE, so a request still high on return to IDLE is treated as a new transaction.
- Simultaneous ack and timeout in the same cycle: ack wins, and m_err = 0.
- Changes on m_addr/m_wdata while BUSY or RESP have no effect; the latched values are held.
- All outputs are registered.

## Timing
- Reset (async assert, sync-to-clk deassert assumed upstream): state = IDLE, and every output is 0 (m_rdata, m_ack, m_err, sN_req, sN_we, sN_addr, sN_wdata, counter).
- Reset mid-transaction: sN_req drops immediately; the in-flight transaction is discarded with no m_ack.
- m_req high at edge k (IDLE) → sN_req high from edge k+1.
- sN_ack sampled high at edge j → sN_req low and m_ack high from edge j+1, for one cycle.
- Zero-wait slave (ack in the first req cycle): m_ack two cycles after the request is accepted.
- Minimum transaction period: 3 cycles (IDLE, BUSY, RESP).
- Timeout: sN_req stays high for exactly TIMEOUT cycles, then m_ack with m_err = 1 follows in the next cycle.

## Test plan
- Reset with all inputs at X→0: every output is 0. Assert rst_n low during BUSY0: s0_req drops asynchronously and no m_ack follows.
- Read addr 0x0000_1000, s0 acks on its 3rd req cycle with 0xDEADBEEF: s0_req is high for 3 cycles, s1_req stays 0, then m_ack = 1, m_rdata = 0xDEADBEEF, m_err = 0.
- Write addr 0xFFFF_0004, data 0x0000_00A5, s1 zero-wait: s1_we = 1, s1_addr = 0xFFFF_0004, s1_wdata = 0xA5; m_ack arrives 2 cycles after acceptance.
- Boundary addresses: 0xFFFE_FFFF routes to s0; 0xFFFF_0000 routes to s1.
- Spurious ack: s1_ack held high during a slave-0 transaction is ignored, and completion follows s0_ack only.
- Timeout with TIMEOUT = 16 and no ack: s0_req is high for 16 cycles, then m_ack = 1, m_err = 1, m_rdata = 0.
  - Repeat with the ack arriving on cycle 16: m_err = 0 and the data is returned.
